nios_project_button_poller: RTL and testbench
=============================================

// Module: nios_project_button_poller
// PURPOSE
// - Avalon-MM read master: the initiator side of the 2-bit button PIO slave (s1; readdata is registered, so read latency is 1).
// - Polls PIO data register (address 0) at a fixed interval, debounces each bit and outputs clean button state.
// - Produces one-cycle press/release pulses and sticky event flags for logic that must not poll.
// PARAMETERS
// - WIDTH           2      number of button bits (readdata[WIDTH-1:0])
// - POLL_CYCLES     50000  clk cycles spent in WAIT between reads (1 ms @ 50 MHz); >=1
// - DEBOUNCE_SAMPLES 4     consecutive differing samples required to flip a bit; 1..15
// - READ_LATENCY    1      fixed slave read latency in cycles; >=1
// - ACTIVE_LOW      1      1: raw 0 = pressed (inverted before debounce)
// PORTS
// - clk             in   1      system clock
// - reset_n         in   1      reset, asynchronous, active-low
// - enable          in   1      1 = polling runs
// - avm_address     out  2      constant 2'd0
// - avm_read        out  1      read strobe
// - avm_waitrequest in   1      slave stall; hold read/address while high
// - avm_readdata    in   32     PIO readdata; bits above WIDTH ignored
// - btn_state       out  WIDTH  debounced level, 1 = pressed
// - btn_press       out  WIDTH  1-cycle pulse, bit went 0->1
// - btn_release     out  WIDTH  1-cycle pulse, bit went 1->0
// - press_flags     out  WIDTH  sticky OR of btn_press
// - event_clear     in   1      clears press_flags
// BEHAVIOUR
// - Reset (async): FSM=IDLE, avm_read=0, all counters 0, btn_state/press/release/press_flags=0. avm_read drops immediately.
// - FSM IDLE: stay while !enable; enable=1 -> WAIT, interval counter loaded with POLL_CYCLES-1.
// - WAIT: count down to 0 -> REQ. Lasts exactly POLL_CYCLES cycles.
// - REQ: avm_read=1. Accepted in a cycle with avm_waitrequest=0 -> LAT (latency counter = READ_LATENCY-1).
// - LAT: avm_read=0. Last LAT cycle (counter=0): capture avm_readdata[WIDTH-1:0] -> sample strobe. Then WAIT if enable, else IDLE.
// - Unstalled period = POLL_CYCLES + 1 + READ_LATENCY cycles. Each wait-state adds 1 cycle. No reads are queued or dropped.
// - enable=0 mid-transaction: finish REQ/LAT (never withdraw read while stalled), then go to IDLE. enable=0 in WAIT: go to IDLE next cycle.
// - Sample raw = captured ^ {WIDTH{ACTIVE_LOW}}.
// - Debounce per bit, on sample strobe only:
//   - raw==state: cnt<=0.
//   - else if cnt==DEBOUNCE_SAMPLES-1: state<=raw, cnt<=0.
//   - else cnt<=cnt+1.
//   - cnt saturates; it never wraps.
// - btn_state updates in the cycle after capture. btn_press/btn_release are high during that same cycle only, never both for one bit.
// - press_flags: flags <= (flags & ~{WIDTH{event_clear}}) | btn_press. A simultaneous set and clear leaves the bit set.
// - Outputs registered; avm_read is a registered FSM decode (high exactly in REQ).
// STRUCTURE
// - Package nios_project_poller_pkg: FSM state localparams (IDLE=0, WAIT=1, REQ=2, LAT=3) and PIO_DATA_ADDR=2'd0.
// - Sub-module nios_project_debounce_bit: one bit's cnt/state/press/release, with inputs sample_valid and raw. Generate it WIDTH times.
// - Top level holds the FSM, interval and latency counters, capture register and press_flags.
// TESTING (POLL_CYCLES=4, DEBOUNCE_SAMPLES=3, READ_LATENCY=1, ACTIVE_LOW=1; model slave = registered PIO)
// - Reset, enable=1, waitrequest=0, in_port=2'b11: reads every 6 cycles with address 0. btn_state=00; no pulses.
// - in_port 11->10 held: on the 3rd sample, btn_state[0]=1 for good, btn_press=01 for 1 cycle, press_flags=01.
// - Bounce 10,11,10,11 on successive samples: btn_state stays 00, no pulses. cnt returns to 0 on each 11 sample.
// - waitrequest held high 5 cycles during REQ: avm_read stays 1, one read only. Next read starts 5 cycles later than unstalled.
// - event_clear asserted in the same cycle as btn_press=10: press_flags[1]=1. Clear alone later: press_flags=00.
// - Drop enable during a stalled REQ: read completes, FSM reaches IDLE, no further reads. reset_n low mid-LAT: avm_read=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/nios_project_poller_pkg.sv
// Shared FSM encodings and PIO register map for the button poller.
// Pure declarations; no latency or flow control of its own.
package nios_project_poller_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] REQ  = 2'd2;
    localparam logic [1:0] LAT  = 2'd3;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Bits needed to hold a down-counter loaded with n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nios_project_debounce_bit.sv
// One-bit debouncer: flips after DEBOUNCE_SAMPLES consecutive differing samples.
// Updates one cycle after sample_valid; pulses last one cycle; no backpressure.
module nios_project_debounce_bit #(
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_valid,
    input  logic raw,
    output logic state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [3:0] LAST = 4'(DEBOUNCE_SAMPLES - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            state         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sample_valid) begin
                if (raw == state) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    state         <= raw;
                    cnt           <= '0;
                    press_pulse   <= raw;
                    release_pulse <= ~raw;
                end else begin
                    // Only reached while cnt < LAST, so the count cannot wrap.
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/nios_project_button_poller.sv
// Avalon-MM read master polling the button PIO, then per-bit debounce and sticky press flags.
// One read per POLL_CYCLES+1+READ_LATENCY cycles; waitrequest stretches the REQ state, nothing is queued.
module nios_project_button_poller
    import nios_project_poller_pkg::*;
#(
    parameter int WIDTH            = 2,
    parameter int POLL_CYCLES      = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int READ_LATENCY     = 1,
    parameter int ACTIVE_LOW       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [WIDTH-1:0]  btn_state,
    output logic [WIDTH-1:0]  btn_press,
    output logic [WIDTH-1:0]  btn_release,
    output logic [WIDTH-1:0]  press_flags,
    input  logic              event_clear
);

    localparam int PCW = cnt_width(POLL_CYCLES);
    localparam int LCW = cnt_width(READ_LATENCY);
    localparam logic [PCW-1:0]   POLL_LOAD = PCW'(POLL_CYCLES - 1);
    localparam logic [LCW-1:0]   LAT_LOAD  = LCW'(READ_LATENCY - 1);
    localparam logic [WIDTH-1:0] POL_MASK  = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PCW-1:0]   poll_cnt;
    logic [LCW-1:0]   lat_cnt;
    logic [WIDTH-1:0] capture;
    logic             sample_vld;
    logic [WIDTH-1:0] raw;

    // PIO bits above WIDTH carry nothing for this block.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:WIDTH];

    assign avm_address = PIO_DATA_ADDR;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = WAIT;
            WAIT: begin
                if (!enable)            state_nxt = IDLE;
                else if (poll_cnt == '0) state_nxt = REQ;
            end
            // A posted read is never withdrawn, even if enable drops meanwhile.
            REQ:  if (!avm_waitrequest) state_nxt = LAT;
            LAT:  if (lat_cnt == '0) state_nxt = enable ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            avm_read   <= 1'b0;
            poll_cnt   <= '0;
            lat_cnt    <= '0;
            capture    <= '0;
            sample_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            avm_read <= (state_nxt == REQ);

            if (state_nxt == WAIT && state != WAIT)
                poll_cnt <= POLL_LOAD;
            else if (state == WAIT && poll_cnt != '0)
                poll_cnt <= poll_cnt - 1'b1;

            if (state == REQ && !avm_waitrequest)
                lat_cnt <= LAT_LOAD;
            else if (state == LAT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;

            sample_vld <= (state == LAT) && (lat_cnt == '0);
            if (state == LAT && lat_cnt == '0)
                capture <= avm_readdata[WIDTH-1:0];
        end
    end

    assign raw = capture ^ POL_MASK;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_project_debounce_bit #(
            .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
        ) u_debounce (
            .clk           (clk),
            .reset_n       (reset_n),
            .sample_valid  (sample_vld),
            .raw           (raw[i]),
            .state         (btn_state[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

    // A press arriving with a clear wins, so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            press_flags <= '0;
        else
            press_flags <= (press_flags & ~{WIDTH{event_clear}}) | btn_press;
    end

endmodule

// File: tb/tb_nios_project_button_poller.sv
// Directed bench: registered PIO slave model, per-sample vector table, hand-written stall/enable/reset sequences.
module tb_nios_project_button_poller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic        event_clear = 1'b0;
    logic [1:0]  in_port = 2'b11;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic [1:0]  btn_state, btn_press, btn_release, press_flags;

    nios_project_button_poller #(
        .WIDTH(2), .POLL_CYCLES(4), .DEBOUNCE_SAMPLES(3), .READ_LATENCY(1), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
        .press_flags(press_flags), .event_clear(event_clear)
    );

    always #5 clk = ~clk;

    // Registered PIO: readdata reflects in_port one cycle later.
    always @(posedge clk) avm_readdata <= {30'd0, in_port};

    int n_vec = 0, n_bad = 0;
    int cyc = 0, acc_cnt = 0, acc_last = 0, acc_prev = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && avm_read && !avm_waitrequest) begin
            acc_prev <= acc_last;
            acc_last <= cyc;
            acc_cnt  <= acc_cnt + 1;
        end
    end

    typedef struct {
        logic [1:0] in;
        logic       clr;
        logic [1:0] st;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] fl;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (avm_read) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_req: no read within 200 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int a0;

        //            in     clr   state  press  rel    flags
        vecs[0]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{2'b10, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01};
        vecs[8]  = '{2'b10, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[9]  = '{2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[10] = '{2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[11] = '{2'b00, 1'b1, 2'b11, 2'b10, 2'b00, 2'b10};
        vecs[12] = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{2'b10, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[14] = '{2'b10, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[15] = '{2'b10, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00};
        vecs[16] = '{2'b11, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[17] = '{2'b11, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[18] = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[19] = '{2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[20] = '{2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[21] = '{2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b11};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_read", {31'd0, avm_read}, 32'd0);
        chk("rst_state", {30'd0, btn_state}, 32'd0);
        chk("rst_press", {30'd0, btn_press}, 32'd0);
        chk("rst_release", {30'd0, btn_release}, 32'd0);
        chk("rst_flags", {30'd0, press_flags}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_no_reads", acc_cnt, 0);

        enable = 1'b1;
        for (int i = 0; i < 22; i++) begin
            in_port = vecs[i].in;
            wait_req(ok);
            if (ok) begin
                chk($sformatf("addr[%0d]", i), {30'd0, avm_address}, 32'd0);
                @(posedge clk);
                @(posedge clk);
                @(posedge clk);
                #1;
                if (i > 0) chk($sformatf("period[%0d]", i), acc_last - acc_prev, 6);
                chk($sformatf("state[%0d]", i), {30'd0, btn_state}, {30'd0, vecs[i].st});
                chk($sformatf("press[%0d]", i), {30'd0, btn_press}, {30'd0, vecs[i].pr});
                chk($sformatf("release[%0d]", i), {30'd0, btn_release}, {30'd0, vecs[i].rl});
                event_clear = vecs[i].clr;
                @(posedge clk);
                #1;
                event_clear = 1'b0;
                chk($sformatf("flags[%0d]", i), {30'd0, press_flags}, {30'd0, vecs[i].fl});
                chk($sformatf("press_gone[%0d]", i), {30'd0, btn_press}, 32'd0);
                chk($sformatf("release_gone[%0d]", i), {30'd0, btn_release}, 32'd0);
            end
        end

        // Five wait-states in REQ: read held, accepted once, period stretched by 5
        wait_req(ok);
        a0 = acc_cnt;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_read_held[%0d]", i), {31'd0, avm_read}, 32'd1);
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_one_accept", acc_cnt, a0 + 1);
        chk("stall_period", acc_last - acc_prev, 11);
        wait_req(ok);
        @(posedge clk);
        #1;
        chk("post_stall_period", acc_last - acc_prev, 6);
        chk("state_before_reset", {30'd0, btn_state}, 32'd3);

        // Asynchronous reset in the middle of LAT
        wait_req(ok);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("lat_rst_read", {31'd0, avm_read}, 32'd0);
        chk("lat_rst_state", {30'd0, btn_state}, 32'd0);
        chk("lat_rst_press", {30'd0, btn_press}, 32'd0);
        chk("lat_rst_release", {30'd0, btn_release}, 32'd0);
        chk("lat_rst_flags", {30'd0, press_flags}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // enable dropped during a stalled REQ: that read completes, then nothing
        wait_req(ok);
        avm_waitrequest = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drop_read_held[%0d]", i), {31'd0, avm_read}, 32'd1);
            @(negedge clk);
        end
        a0 = acc_cnt;
        avm_waitrequest = 1'b0;
        repeat (20) @(negedge clk);
        chk("drop_one_accept", acc_cnt, a0 + 1);
        chk("drop_read_low", {31'd0, avm_read}, 32'd0);

        // enable dropped in WAIT: back to IDLE before any read
        enable = 1'b1;
        a0 = acc_cnt;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("wait_drop_no_read", acc_cnt, a0);
        chk("wait_drop_read_low", {31'd0, avm_read}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
